fft_input_loader: RTL and testbench
===================================

// Module: fft_input_loader
// PURPOSE
//  Stage directly upstream of Butterfly. Accepts a serial stream of complex 16-bit samples over a
//  valid/ready handshake and writes each sample into a D_WIDTH-entry buffer at its bit-reversed index.
//  Presents the buffer as the parallel input_Re/input_Im arrays Butterfly expects.
//  Pulses start for one cycle when a frame completes, then stalls input for the Butterfly compute window.
// PARAMETERS
//  D_WIDTH      64   samples per frame (power of two)
//  LOG_2_WIDTH  6    log2(D_WIDTH); index and bit-reversal width
//  HOLD_CYCLES  192  cycles in_ready stays low after start ((D_WIDTH/2)*LOG_2_WIDTH butterfly ops); must be >=1
// PORTS
//  clk        in   1                 single clock; all flops update on falling edge (matches Butterfly)
//  rst        in   1                 asynchronous, active-low reset
//  in_valid   in   1                 sample present on in_re/in_im/in_last
//  in_ready   out  1                 loader accepts a sample this cycle
//  in_re      in   16                sample real part, two's complement
//  in_im      in   16                sample imaginary part, two's complement
//  in_last    in   1                 marks sample D_WIDTH-1 of a frame
//  out_re     out  16 x D_WIDTH      bit-reversed buffer, real; feeds Butterfly input_Re
//  out_im     out  16 x D_WIDTH      bit-reversed buffer, imag; feeds Butterfly input_Im
//  start      out  1                 one-cycle pulse, frame ready; feeds Butterfly start
//  busy       out  1                 high in FIRE and HOLD
//  frame_err  out  1                 one-cycle pulse on framing error
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state=FILL; sample count=0; hold counter=0.
//   - All out_re/out_im entries = 0; start=0, busy=0, frame_err=0.
//   - in_ready=0 while rst=0.
//  Accept rule: a sample is accepted on a falling edge where in_valid & in_ready.
//  FILL (in_ready=1):
//   - An accepted sample n is written to out_re/out_im[bitrev(n)]; count increments.
//   - A non-accepted cycle leaves the buffer and count unchanged.
//  Frame completion:
//   - Accept with n==D_WIDTH-1 and in_last=1: write sample, count->0, go to FIRE.
//  Framing errors (sample discarded, buffer not written, count->0, stay FILL, frame_err=1 next cycle):
//   - in_last=1 with n<D_WIDTH-1.
//   - in_last=0 with n==D_WIDTH-1.
//   - Buffer entries already written are NOT cleared; the next frame overwrites them.
//  FIRE (one cycle):
//   - start=1, busy=1, in_ready=0; load hold counter with HOLD_CYCLES; next state HOLD.
//   - start is registered: it is high for exactly the cycle after the final accept.
//   - out arrays are stable throughout that cycle.
//  HOLD:
//   - busy=1, in_ready=0; hold counter decrements each cycle; at 1 go to FILL.
//   - in_ready is low for exactly 1+HOLD_CYCLES cycles per frame.
//   - Buffer is never written in FIRE/HOLD.
//  Butterfly latches inputs only while start=1, so refilling during the next FILL is safe.
//  rst asserted in any state: immediate return to reset values; a partial frame is dropped, no start.
//  Widths: count is LOG_2_WIDTH bits; the hold counter is $clog2(HOLD_CYCLES+1) bits; samples pass unmodified.
// STRUCTURE
//  Package fft_pkg holds:
//   - SAMPLE_W=16 and the state enum {FILL, FIRE, HOLD}.
//   - function bitrev(idx, LOG_2_WIDTH), shared with other FFT stages.
//  No sub-module: one FSM, two counters, and a generate loop of per-entry write-enable registers.
// TESTING
//  1 Reset: drop rst mid-FILL after 20 samples -> all outputs 0; after release in_ready=1; a fresh 64-sample frame completes normally.
//  2 Ramp frame re=n, im=-n, in_valid=1 continuous:
//     -> out_re[32]=1, out_re[1]=32, out_re[63]=63, out_im[32]=16'hFFFF.
//     -> start high exactly one cycle, on the cycle after the 64th accept.
//  3 Same ramp with random in_valid gaps -> identical buffer contents; start still one cycle only.
//  4 in_last on sample 10 -> frame_err one cycle, no start; next 64-sample frame loads correctly and fires.
//  5 Back-to-back frames with in_valid held high -> in_ready low for 193 cycles between frames; second start occurs 64 accepts after FILL resumes.
//  6 rst asserted during HOLD (cycle 50) -> busy=0, state FILL after release; no start until a full new frame arrives.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: sample width, loader state encoding and index bit-reversal.
package fft_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Reverse the low 'width' bits of idx; bits above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < width; b++) begin
      r = {r[30:0], idx[b]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_loader.sv
// Serial-to-parallel loader in front of Butterfly.
// Samples arrive over valid/ready and land at their bit-reversed buffer index.
// A completed frame fires a one-cycle start.
// Input is then stalled for the butterfly compute window.
// All flops use the falling clock edge to line up with Butterfly.
//
//   state | meaning
//   FILL  | accepting samples, count = index of next sample
//   FIRE  | frame complete, start high, hold counter loaded
//   HOLD  | Butterfly computing, input stalled until hold counter expires
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int HOLD_CYCLES = 192
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SAMPLE_W-1:0]               in_re,
  input  logic [SAMPLE_W-1:0]               in_im,
  input  logic                              in_last,
  output logic [D_WIDTH-1:0][SAMPLE_W-1:0]  out_re,
  output logic [D_WIDTH-1:0][SAMPLE_W-1:0]  out_im,
  output logic                              start,
  output logic                              busy,
  output logic                              frame_err
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_t                 r_state;
  logic [LOG_2_WIDTH-1:0] r_count;
  logic [HOLD_W-1:0]      r_hold;
  logic                   r_start;
  logic                   r_busy;
  logic                   r_frame_err;

  logic                   w_accept;
  logic                   w_at_end;
  logic                   w_bad;
  logic                   w_write;
  logic [LOG_2_WIDTH-1:0] w_wr_idx;

  // Ready is gated by reset directly so it is low for the whole time rst is held.
  assign in_ready  = rst && (r_state == FILL);
  assign w_accept  = in_valid && in_ready;
  assign w_at_end  = (r_count == LOG_2_WIDTH'(D_WIDTH - 1));
  // in_last must coincide exactly with the final index; any disagreement is a framing error.
  assign w_bad     = in_last ^ w_at_end;
  assign w_write   = w_accept && !w_bad;
  assign w_wr_idx  = LOG_2_WIDTH'(bitrev(32'(r_count), LOG_2_WIDTH));

  assign start     = r_start;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

  // Frame sequencing: sample count, fire pulse, stall timer and error pulse.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL;
      r_count     <= '0;
      r_hold      <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_start     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_bad) begin
              r_count     <= '0;
              r_frame_err <= 1'b1;
            end else if (w_at_end) begin
              r_count <= '0;
              r_start <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= FIRE;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        FIRE: begin
          r_hold  <= HOLD_W'(HOLD_CYCLES);
          r_state <= HOLD;
        end
        HOLD: begin
          if (r_hold == HOLD_W'(1)) begin
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_state <= FILL;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  for (genvar gi = 0; gi < D_WIDTH; gi++) begin : g_entry
    logic [SAMPLE_W-1:0] r_re;
    logic [SAMPLE_W-1:0] r_im;

    // Entry captures the accepted sample whose bit-reversed index selects it.
    always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
        r_re <= '0;
        r_im <= '0;
      end else if (w_write && (w_wr_idx == LOG_2_WIDTH'(gi))) begin
        r_re <= in_re;
        r_im <= in_im;
      end
    end

    assign out_re[gi] = r_re;
    assign out_im[gi] = r_im;
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: expected frames are queued as they are
// driven and compared against the parallel buffer whenever start pulses.
module tb_fft_input_loader;

  localparam int D    = 64;
  localparam int HOLD = 192;

  typedef struct packed {
    logic [D-1:0][15:0] re;
    logic [D-1:0][15:0] im;
  } frame_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        in_re;
  logic [15:0]        in_im;
  logic               in_last;
  logic [D-1:0][15:0] out_re;
  logic [D-1:0][15:0] out_im;
  logic               start;
  logic               busy;
  logic               frame_err;

  int     checks = 0;
  int     errors = 0;
  frame_t exp_q[$];
  frame_t mon_f;
  int     n_pushed = 0;
  int     n_start = 0;
  logic   prev_start = 1'b0;
  int     low_run = 0;
  int     last_low_run = 0;
  int     starts_before;

  always #5 clk = ~clk;

  fft_input_loader #(.D_WIDTH(D), .LOG_2_WIDTH(6), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .out_re(out_re), .out_im(out_im),
    .start(start), .busy(busy), .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev6(input int n);
    int r = 0;
    for (int b = 0; b < 6; b++) r = (r << 1) | ((n >> b) & 1);
    return r;
  endfunction

  // Monitor on the rising edge, half a cycle away from the DUT's falling active edge.
  always @(posedge clk) begin
    if (!rst) begin
      prev_start = 1'b0;
      low_run    = 0;
    end else begin
      if (start) begin
        n_start++;
        check("start_width", prev_start, 0);
        check("busy_at_start", busy, 1);
        if (exp_q.size() == 0) begin
          check("start_unexpected", 1, 0);
        end else begin
          mon_f = exp_q.pop_front();
          for (int i = 0; i < D; i++) begin
            check($sformatf("buf_re[%0d]", i), out_re[i], mon_f.re[i]);
            check($sformatf("buf_im[%0d]", i), out_im[i], mon_f.im[i]);
          end
        end
      end
      prev_start = start;
      if (!in_ready) low_run++;
      else begin
        if (low_run > 0) last_low_run = low_run;
        low_run = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last, input int idle);
    bit acc = 1'b0;
    if (idle > 0) begin
      in_valid = 1'b0;
      repeat (idle) step();
    end
    in_re = re; in_im = im; in_last = last; in_valid = 1'b1;
    for (int t = 0; t < 400 && !acc; t++) begin
      acc = in_ready;
      step();
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  // kind 0: ramp re=n, im=-n; kind 1: random samples.
  task automatic send_frame(input int kind, input int gap_max, input bit keep_valid);
    frame_t      f;
    logic [15:0] sre [D];
    logic [15:0] sim [D];
    int          idle;
    f = '0;
    for (int n = 0; n < D; n++) begin
      if (kind == 0) begin
        sre[n] = 16'(n);
        sim[n] = 16'(-n);
      end else begin
        sre[n] = 16'($urandom);
        sim[n] = 16'($urandom);
      end
      f.re[rev6(n)] = sre[n];
      f.im[rev6(n)] = sim[n];
    end
    exp_q.push_back(f);
    n_pushed++;
    for (int n = 0; n < D; n++) begin
      idle = 0;
      if (gap_max > 0 && $urandom_range(0, 2) == 0) idle = $urandom_range(1, gap_max);
      send(sre[n], sim[n], n == D - 1, idle);
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Called right after the final accept of a ramp frame.
  task automatic ramp_checks();
    check("ramp_start_now", start, 1);
    check("ramp_re32", out_re[32], 16'd1);
    check("ramp_re1", out_re[1], 16'd32);
    check("ramp_re63", out_re[63], 16'd63);
    check("ramp_im32", out_im[32], 16'hFFFF);
    step();
    check("ramp_start_gone", start, 0);
    check("ramp_busy_hold", busy, 1);
    check("ramp_ready_hold", in_ready, 0);
  endtask

  task automatic wait_fill();
    for (int t = 0; t < 400 && !in_ready; t++) step();
    check("fill_timeout", in_ready, 1);
    check("fill_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0;
    repeat (3) step();
    check("rst_ready", in_ready, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", frame_err, 0);
    check("rst_buf", |{out_re, out_im}, 0);
    rst = 1'b1;
    #1;
    check("rel_ready", in_ready, 1);

    // Partial frame dropped by reset.
    for (int n = 0; n < 20; n++) send(16'(n + 100), 16'(n + 1), 1'b0, 0);
    in_valid = 1'b0;
    check("partial_buf_written", out_re[rev6(5)], 16'd105);
    rst = 1'b0;
    #1;
    check("midrst_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_buf", |{out_re, out_im}, 0);
    step();
    rst = 1'b1;
    #1;
    check("midrst_rel_ready", in_ready, 1);
    send_frame(1, 0, 0);
    check("fresh_start", start, 1);
    wait_fill();

    // Ramp, continuous and gapped.
    send_frame(0, 0, 0);
    ramp_checks();
    wait_fill();
    send_frame(0, 3, 0);
    ramp_checks();
    wait_fill();

    // Early in_last on sample 10.
    for (int n = 0; n < 10; n++) send(16'(n), 16'(n), 1'b0, 0);
    send(16'h7777, 16'h7777, 1'b1, 0);
    in_valid = 1'b0;
    check("early_last_err", frame_err, 1);
    check("early_last_nostart", start, 0);
    check("early_last_nowrite", out_re[rev6(10)], 16'd10);
    step();
    check("early_last_err_gone", frame_err, 0);
    check("early_last_ready", in_ready, 1);
    send_frame(1, 1, 0);
    check("after_err_start", start, 1);
    wait_fill();

    // Missing in_last on sample 63.
    for (int n = 0; n < D; n++) send(16'(n + 7), 16'(n), 1'b0, 0);
    in_valid = 1'b0;
    check("no_last_err", frame_err, 1);
    check("no_last_nostart", start, 0);
    step();
    check("no_last_err_gone", frame_err, 0);
    send_frame(1, 0, 0);
    wait_fill();

    // Back-to-back frames, valid held high.
    send_frame(1, 0, 1);
    send_frame(1, 0, 0);
    check("b2b_start", start, 1);
    check("b2b_low_run", last_low_run, HOLD + 1);
    wait_fill();

    // Reset 50 cycles into the compute window.
    send_frame(1, 0, 0);
    repeat (50) step();
    check("hold_busy", busy, 1);
    check("hold_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("holdrst_busy", busy, 0);
    check("holdrst_start", start, 0);
    check("holdrst_buf", |{out_re, out_im}, 0);
    step();
    rst = 1'b1;
    #1;
    check("holdrst_ready", in_ready, 1);
    starts_before = n_start;
    repeat (250) step();
    check("holdrst_no_start", n_start, starts_before);
    check("holdrst_still_fill", in_ready, 1);
    send_frame(0, 0, 0);
    ramp_checks();
    wait_fill();

    repeat (5) step();
    check("queue_drained", exp_q.size(), 0);
    check("start_count", n_start, n_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
